approx_mult_err_monitor: RTL and testbench

- Downstream characterisation stage for the 8x8 unsigned approximate multipliers.
- Consumes a stream of operand pairs (x, y) together with the approximate product z_approx produced by the multiplier under test.
- Computes the exact product internally and accumulates error statistics over a programmed number of samples: error count, sum of error distance, signed error sum and maximum error distance.
- Results are exposed for the characterisation harness to read.

---
 rtl/approx_mult_pkg.sv | 22 ++
 rtl/approx_mult_err_monitor_err_stat_accum.sv | 82 ++++++++
 rtl/approx_mult_err_monitor.sv | 122 ++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared widths and FSM state encoding for the approximate-multiplier error monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package approx_mult_pkg;

    // Default operand width and sample-counter width.
    localparam int DEF_W     = 8;
    localparam int DEF_CNT_W = 16;

    // Derived widths at the default sizing.
    localparam int ED_W   = 2 * DEF_W;           // error distance / product width
    localparam int SUM_W  = ED_W + DEF_CNT_W;    // sum of error distances
    localparam int SERR_W = SUM_W + 1;           // signed error sum

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/approx_mult_err_monitor_err_stat_accum.sv
// err_stat_accum: S2 of the monitor; forms z_approx - exact, |diff|, and accumulates the statistics.
// Latency: statistics registers reflect an enabled sample on the next clock edge.
// Backpressure: none; en is a pure valid, every enabled cycle is absorbed.
// Ports: clk/rst (async active-high), clr (synchronous clear, wins over en), en (S1 valid),
//        exact/z_approx (S1 registers), sample_cnt/err_cnt/sum_ed/sum_err/max_ed (statistics).
module err_stat_accum #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [2*W-1:0]       exact,
    input  logic [2*W-1:0]       z_approx,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [2*W+CNT_W-1:0] sum_ed,
    output logic [2*W+CNT_W:0]   sum_err,
    output logic [2*W-1:0]       max_ed
);

    logic [2*W:0]         diff;
    logic [2*W-1:0]       ed;

    logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic [2*W+CNT_W-1:0] sum_ed_q, sum_ed_d;
    logic [2*W+CNT_W:0]   sum_err_q, sum_err_d;
    logic [2*W-1:0]       max_ed_q, max_ed_d;

    // Both operands are zero-extended by one bit, so diff[2W] is the sign.
    assign diff = {1'b0, z_approx} - {1'b0, exact};
    // Magnitude taken by subtracting in the right order, which always fits 2W bits.
    assign ed   = diff[2*W] ? (exact - z_approx) : (z_approx - exact);

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_ed_d     = sum_ed_q;
        sum_err_d    = sum_err_q;
        max_ed_d     = max_ed_q;
        if (clr) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sum_ed_d     = '0;
            sum_err_d    = '0;
            max_ed_d     = '0;
        end else if (en) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            err_cnt_d    = err_cnt_q + CNT_W'(diff != '0);
            sum_ed_d     = sum_ed_q + {{CNT_W{1'b0}}, ed};
            sum_err_d    = sum_err_q + {{CNT_W{diff[2*W]}}, diff};
            if (ed > max_ed_q) begin
                max_ed_d = ed;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_ed_q     <= '0;
            sum_err_q    <= '0;
            max_ed_q     <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_ed_q     <= sum_ed_d;
            sum_err_q    <= sum_err_d;
            max_ed_q     <= max_ed_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sum_ed     = sum_ed_q;
    assign sum_err    = sum_err_q;
    assign max_ed     = max_ed_q;

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Characterises an 8x8 approximate multiplier: counts errors, sums |err| and err, tracks max |err|.
// Latency: stats reflect a sample 2 cycles after acceptance; done rises 3 cycles after the last accept.
// Backpressure: in_ready only in RUN while fewer than N samples accepted; one sample per clock sustained.
// Ports: clk, rst (async active-high), start/num_samples (run control), in_valid/in_ready/x/y/z_approx
//        (sample stream), busy/done (status), sample_cnt/err_cnt/sum_ed/sum_err/max_ed (results).
module approx_mult_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         x,
    input  logic [W-1:0]         y,
    input  logic [2*W-1:0]       z_approx,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [2*W+CNT_W-1:0] sum_ed,
    output logic [2*W+CNT_W:0]   sum_err,
    output logic [2*W-1:0]       max_ed
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             s1_vld_q, s1_vld_d;
    logic [2*W-1:0]   exact_q, exact_d;
    logic [2*W-1:0]   zapx_q, zapx_d;
    logic             accept;
    logic             stat_clr;

    assign in_ready = (state_q == RUN) && (acc_q < n_q);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    // Statistics clear on a start seen in IDLE or DONE; the pipeline is empty then.
    assign stat_clr = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d     = num_samples;
                    acc_d   = '0;
                    state_d = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_d == n_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The S2 update of the last sample lands on the same edge S1 empties.
                if (!s1_vld_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // S1: exact product and the DUT's approximate product for each accepted sample.
    always_comb begin
        s1_vld_d = accept;
        exact_d  = exact_q;
        zapx_d   = zapx_q;
        if (accept) begin
            exact_d = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            zapx_d  = z_approx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            acc_q    <= '0;
            s1_vld_q <= 1'b0;
            exact_q  <= '0;
            zapx_q   <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            acc_q    <= acc_d;
            s1_vld_q <= s1_vld_d;
            exact_q  <= exact_d;
            zapx_q   <= zapx_d;
        end
    end

    err_stat_accum #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clr        (stat_clr),
        .en         (s1_vld_q),
        .exact      (exact_q),
        .z_approx   (zapx_q),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt),
        .sum_ed     (sum_ed),
        .sum_err    (sum_err),
        .max_ed     (max_ed)
    );

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Bench for approx_mult_err_monitor: scenario tasks with a plain-arithmetic reference model.
// Latency: checks done 3 cycles after last accept, 1 cycle after a zero-length start.
// Backpressure: drives in_valid with and without gaps, watches in_ready.
module tb_approx_mult_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x, y;
    logic [15:0] z_approx;
    logic        busy, done;
    logic [15:0] sample_cnt, err_cnt;
    logic [31:0] sum_ed;
    logic [32:0] sum_err;
    logic [15:0] max_ed;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sx[$];
    logic [7:0]  sy[$];
    logic [15:0] sz[$];

    longint e_cnt, e_err, e_sed, e_serr, e_max;

    always #5 clk = ~clk;

    approx_mult_err_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .y           (y),
        .z_approx    (z_approx),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .err_cnt     (err_cnt),
        .sum_ed      (sum_ed),
        .sum_err     (sum_err),
        .max_ed      (max_ed)
    );

    // Reference: statistics straight from the sample list with integer arithmetic.
    function automatic void compute_model();
        e_cnt = sx.size(); e_err = 0; e_sed = 0; e_serr = 0; e_max = 0;
        foreach (sx[i]) begin
            longint p, d, a;
            p = longint'(sx[i]) * longint'(sy[i]);
            d = longint'(sz[i]) - p;
            a = (d < 0) ? -d : d;
            if (d != 0) e_err++;
            e_sed += a;
            e_serr += d;
            if (a > e_max) e_max = a;
        end
    endfunction

    // Stimulus only: starts a run of n samples from sx/sy/sz, optionally with in_valid gaps,
    // optionally pulsing start (N=1) at loop cycle poke. Returns accepts, cycles used,
    // cycles from last accept (or start) to done, sample_cnt right after start, busy seen.
    task automatic drive_run(input int n, input bit gaps, input int poke,
                             output int acc, output int cyc, output int lat,
                             output logic [15:0] cnt0, output bit busy_seen);
        logic rdy;
        acc = 0; cyc = 0; lat = -1; busy_seen = 0;
        start = 1'b1; num_samples = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        cnt0 = sample_cnt;
        while (acc < n && cyc < 4000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            x = sx[acc]; y = sy[acc]; z_approx = sz[acc];
            start = (cyc == poke);
            num_samples = (cyc == poke) ? 16'd1 : 16'(n);
            rdy = in_ready;
            if (busy) busy_seen = 1;
            @(posedge clk);
            cyc++;
            if (in_valid && rdy) acc++;
            #1;
        end
        start = 1'b0; in_valid = 1'b0; num_samples = 16'(n);
        for (int k = 0; k < 50; k++) begin
            if (busy) busy_seen = 1;
            if (done) begin
                lat = k + 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic fill_random(input int n);
        sx.delete(); sy.delete(); sz.delete();
        for (int i = 0; i < n; i++) begin
            int p, d, mode;
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            p = int'(a) * int'(b);
            d = $urandom_range(1, 300);
            mode = $urandom_range(0, 3);
            sx.push_back(a); sy.push_back(b);
            if (mode == 1)                       sz.push_back(16'($urandom_range(0, 65535)));
            else if (mode == 2 && p + d < 65536) sz.push_back(16'(p + d));
            else if (mode == 3 && p >= d)        sz.push_back(16'(p - d));
            else                                 sz.push_back(16'(p));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, busy, done} !== 3'b000)
            $display("FAIL reset_ctrl: got ready/busy/done=%b want 000", {in_ready, busy, done});
        checks++;
        if (sample_cnt !== 0 || err_cnt !== 0 || sum_ed !== 0 || sum_err !== 0 || max_ed !== 0)
            $display("FAIL reset_stats: got cnt=%0d err=%0d sed=%0d serr=%0d max=%0d want all 0",
                     sample_cnt, err_cnt, sum_ed, sum_err, max_ed);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, busy, done} !== 3'b000)
            $display("FAIL reset_idle: got ready/busy/done=%b want 000", {in_ready, busy, done});
    endtask

    task automatic test_zero_length();
        int acc, cyc, lat; logic [15:0] c0; bit bs;
        sx.delete(); sy.delete(); sz.delete();
        compute_model();
        drive_run(0, 0, -1, acc, cyc, lat, c0, bs);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL zero_done_lat: got %0d want 1", lat); end
        checks++;
        if (bs !== 1'b0) begin errors++; $display("FAIL zero_busy: got busy seen=%0d want 0", bs); end
        checks++;
        if (sample_cnt !== 16'(e_cnt) || sum_ed !== 32'(e_sed) || max_ed !== 16'(e_max)) begin
            errors++;
            $display("FAIL zero_stats: got cnt=%0d sed=%0d max=%0d want 0", sample_cnt, sum_ed, max_ed);
        end
    endtask

    task automatic test_exact();
        int acc, cyc, lat; logic [15:0] c0; bit bs;
        sx = '{8'd3, 8'd255, 8'd0, 8'd16};
        sy = '{8'd5, 8'd255, 8'd7, 8'd16};
        sz = '{16'd15, 16'd65025, 16'd0, 16'd256};
        compute_model();
        drive_run(4, 0, -1, acc, cyc, lat, c0, bs);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL exact_ready_cycles: got %0d want 4", cyc); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL exact_done_lat: got %0d want 3", lat); end
        checks++;
        if (sample_cnt !== 16'(e_cnt)) begin errors++; $display("FAIL exact_cnt: got %0d want %0d", sample_cnt, e_cnt); end
        checks++;
        if (err_cnt !== 16'(e_err) || sum_ed !== 32'(e_sed) || sum_err !== 33'(e_serr) || max_ed !== 16'(e_max)) begin
            errors++;
            $display("FAIL exact_stats: got err=%0d sed=%0d serr=%0d max=%0d want 0", err_cnt, sum_ed, sum_err, max_ed);
        end
    endtask

    task automatic test_mixed();
        int acc, cyc, lat; logic [15:0] c0; bit bs;
        sx = '{8'd255, 8'd10, 8'd2};
        sy = '{8'd255, 8'd10, 8'd3};
        sz = '{16'd65000, 16'd104, 16'd6};
        compute_model();
        drive_run(3, 0, -1, acc, cyc, lat, c0, bs);
        checks++;
        if (err_cnt !== 16'(e_err)) begin errors++; $display("FAIL mixed_err: got %0d want %0d", err_cnt, e_err); end
        checks++;
        if (sum_ed !== 32'(e_sed)) begin errors++; $display("FAIL mixed_sum_ed: got %0d want %0d", sum_ed, e_sed); end
        checks++;
        if (sum_err !== 33'(e_serr)) begin errors++; $display("FAIL mixed_sum_err: got %0d want %0d", $signed(sum_err), e_serr); end
        checks++;
        if (max_ed !== 16'(e_max)) begin errors++; $display("FAIL mixed_max: got %0d want %0d", max_ed, e_max); end
    endtask

    task automatic test_handshake();
        int accepts;
        bit pat[6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rst = 1'b1; #2; rst = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; x = 8'd3; y = 8'd3; z_approx = 16'd9;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", in_ready); end
            @(posedge clk); #1;
        end
        checks++;
        if (sample_cnt !== 16'd0) begin errors++; $display("FAIL idle_cnt: got %0d want 0", sample_cnt); end
        in_valid = 1'b0;
        start = 1'b1; num_samples = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            if (in_valid && in_ready) accepts++;
            @(posedge clk); #1;
        end
        checks++;
        if (accepts !== 2) begin errors++; $display("FAIL hs_accepts: got %0d want 2", accepts); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_after: got %b want 0", in_ready); end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sample_cnt !== 16'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL hs_final: got cnt=%0d done=%b want cnt=2 done=1", sample_cnt, done);
        end
    endtask

    task automatic test_restart_ignore();
        int acc, cyc, lat; logic [15:0] c0; bit bs;
        fill_random(3);
        compute_model();
        drive_run(3, 0, 1, acc, cyc, lat, c0, bs);
        checks++;
        if (acc !== 3 || cyc !== 3) begin errors++; $display("FAIL run_start_ignored: got acc=%0d cyc=%0d want 3/3", acc, cyc); end
        checks++;
        if (sample_cnt !== 16'(e_cnt) || sum_ed !== 32'(e_sed) || sum_err !== 33'(e_serr)) begin
            errors++;
            $display("FAIL run_start_stats: got cnt=%0d sed=%0d serr=%0d want %0d/%0d/%0d",
                     sample_cnt, sum_ed, $signed(sum_err), e_cnt, e_sed, e_serr);
        end
        sx = '{8'd1}; sy = '{8'd1}; sz = '{16'd0};
        compute_model();
        drive_run(1, 0, -1, acc, cyc, lat, c0, bs);
        checks++;
        if (c0 !== 16'd0) begin errors++; $display("FAIL done_restart_clear: got cnt=%0d want 0", c0); end
        checks++;
        if (err_cnt !== 16'(e_err) || sum_err !== 33'(e_serr) || max_ed !== 16'(e_max)) begin
            errors++;
            $display("FAIL done_restart_stats: got err=%0d serr=%0d max=%0d want %0d/%0d/%0d",
                     err_cnt, $signed(sum_err), max_ed, e_err, e_serr, e_max);
        end
    endtask

    task automatic test_random_gaps();
        int acc, cyc, lat, n; logic [15:0] c0; bit bs;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(20, 60);
            fill_random(n);
            compute_model();
            drive_run(n, 1, -1, acc, cyc, lat, c0, bs);
            checks++;
            if (acc !== n || lat !== 3) begin errors++; $display("FAIL rnd_flow: got acc=%0d lat=%0d want %0d/3", acc, lat, n); end
            checks++;
            if (sample_cnt !== 16'(e_cnt) || err_cnt !== 16'(e_err)) begin
                errors++;
                $display("FAIL rnd_counts: got cnt=%0d err=%0d want %0d/%0d", sample_cnt, err_cnt, e_cnt, e_err);
            end
            checks++;
            if (sum_ed !== 32'(e_sed) || sum_err !== 33'(e_serr) || max_ed !== 16'(e_max)) begin
                errors++;
                $display("FAIL rnd_sums: got sed=%0d serr=%0d max=%0d want %0d/%0d/%0d",
                         sum_ed, $signed(sum_err), max_ed, e_sed, e_serr, e_max);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc, cyc, lat, n; logic [15:0] c0; bit bs;
        n = $urandom_range(30, 80);
        fill_random(n);
        compute_model();
        drive_run(n, 0, -1, acc, cyc, lat, c0, bs);
        checks++;
        if (cyc !== n) begin errors++; $display("FAIL b2b_rate: got %0d cycles want %0d", cyc, n); end
        checks++;
        if (sum_err !== 33'(e_serr) || sum_ed !== 32'(e_sed) || sample_cnt !== 16'(e_cnt)) begin
            errors++;
            $display("FAIL b2b_stats: got serr=%0d sed=%0d cnt=%0d want %0d/%0d/%0d",
                     $signed(sum_err), sum_ed, sample_cnt, e_serr, e_sed, e_cnt);
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1; num_samples = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; x = 8'd7; y = 8'd9; z_approx = 16'd64;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || sample_cnt !== 16'd1 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset: got busy=%b cnt=%0d err=%0d want 1/1/1", busy, sample_cnt, err_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL arst_ctrl: got ready/busy/done=%b want 000", {in_ready, busy, done});
        end
        checks++;
        if (sample_cnt !== 0 || err_cnt !== 0 || sum_ed !== 0 || sum_err !== 0 || max_ed !== 0) begin
            errors++;
            $display("FAIL arst_stats: got cnt=%0d err=%0d sed=%0d serr=%0d max=%0d want all 0",
                     sample_cnt, err_cnt, sum_ed, sum_err, max_ed);
        end
        #1 rst = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, busy, done} !== 3'b000 || sample_cnt !== 16'd0) begin
            errors++;
            $display("FAIL arst_idle: got ready/busy/done=%b cnt=%0d want 000/0", {in_ready, busy, done}, sample_cnt);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = 16'd0; in_valid = 1'b0;
        x = 8'd0; y = 8'd0; z_approx = 16'd0;
        test_reset();
        test_zero_length();
        test_exact();
        test_mixed();
        test_handshake();
        test_restart_ignore();
        test_random_gaps();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
